flappy_game_engine: RTL and testbench
=====================================

// Module: flappy_game_engine
// PURPOSE
//  Hardware game-state engine feeding vga_controller. Once per video frame it advances bird physics,
//  scrolls and respawns two pipe pairs, detects collisions and tracks the score. Outputs are the
//  zero-extended 32-bit position words and gameover_flag that vga_controller latches every 30 frames.
//  Sits between the button/VS-tick logic and vga_controller.
// PARAMETERS
//  SCREEN_H      480   playfield height (px); ground = bird bottom reaching this
//  BIRD_X        320   fixed bird left edge (must match vga_controller)
//  BIRD_W        45    bird box width;  BIRD_H 35 bird box height
//  PIPE_W        54    pipe width, centred on pipe_x (half = 27)
//  GAP           150   vertical gap, centred on pipe_y (half = 75)
//  GRAVITY       1     px/frame^2 added to velocity each frame
//  FLAP_VEL      9     velocity set to -FLAP_VEL on a flap
//  MAX_FALL      10    downward velocity saturation
//  SCROLL        2     pipe leftward step per frame
//  BIRD_Y0       200   bird top at init
//  PIPE1_X0      640   pipe1 centre at init;  pipe2 init = PIPE1_X0 + SPACING
//  SPACING       347   pipe centre spacing;  WRAP = 2*SPACING = 694
// PORTS
//  iCLK          in   1   system clock (VGA clock domain)
//  iRST          in   1   asynchronous, active-high reset
//  iFRAME_TICK   in   1   one-cycle pulse per frame (VS start); synchronous to iCLK
//  iFLAP         in   1   flap button level, already synchronised/debounced
//  bird_y_long   out  32  bird top y, bits[31:11]=0
//  pipe1_x_long  out  32  pipe1 centre x;  pipe1_y_long out 32 pipe1 gap centre y
//  pipe2_x_long  out  32  pipe2 centre x;  pipe2_y_long out 32 pipe2 gap centre y
//  gameover_flag out  1   1 while in DEAD
//  oSCORE        out  16  pipes passed, saturates at 16'hFFFF
//  oSTATE        out  2   00 IDLE, 01 PLAY, 10 DEAD
// BEHAVIOUR
//  Reset (async, iRST=1): state=IDLE; bird_y=200; vel=0; pipe1_x=640, pipe2_x=987;
//   pipe1_y=pipe2_y=240; score=0; gameover_flag=0; LFSR=8'hB5; flap latch=0.
//  Internals: positions 11-bit unsigned, vel 8-bit signed. 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   steps once per frame tick in every state.
//  Flap: rising edge of iFLAP (registered prev) sets flap latch; cleared on the tick that consumes it.
//   An edge coincident with iFRAME_TICK is consumed by that tick.
//  IDLE: all positions held. Flap edge -> PLAY (latch kept; first PLAY tick applies the flap).
//  PLAY, on each iFRAME_TICK (stage 1, registered same edge):
//   - vel_n = latch ? -FLAP_VEL : min(vel+GRAVITY, MAX_FALL);  y_n = y + vel_n, clamped to 0 if <0.
//   - each pipe: x_n = x - SCROLL; if x_n < 27+SCROLL then x_n += WRAP and pipe_y = 105 + LFSR[7:0]
//     (range 105..360).
//   - score += 1 (saturating) for each pipe whose x crosses from >= BIRD_X-27 to < BIRD_X-27.
//  Collision (stage 2, cycle after stage-1 update, uses new values):
//   - x overlap: BIRD_X+BIRD_W > px-27 and BIRD_X < px+27;
//   - hit if overlap and (y < py-75 or y+BIRD_H > py+75); ground if y+BIRD_H >= SCREEN_H.
//   - hit/ground -> DEAD; gameover_flag=1 at end of that cycle (2 clocks after tick).
//  DEAD: all positions, vel, score frozen. Flap edge -> reinit to reset values except score kept on
//   oSCORE until next PLAY entry (score cleared on IDLE->PLAY) -> IDLE; gameover_flag=0 next cycle.
//  Ticks arriving while stage 2 pending (ticks < 2 cycles apart) are illegal; not required.
//  iRST mid-frame/mid-update: outputs return to reset values immediately; no partial update.
//  Output words always zero-extended; no combinational path from inputs to outputs.
// TESTING
//  1 Reset, 10 ticks no flap -> IDLE, bird_y=200, pipe1_x=640, gameover_flag=0 throughout.
//  2 Flap edge, then 3 ticks no flap -> vel -9,-8,-7; bird_y 191,183,176; pipe1_x 638,636,634.
//  3 PLAY with no flaps -> vel saturates at 10; bird_y+35>=480 -> gameover_flag=1 2 clks after tick.
//  4 Force pipe1_x=30 via play -> next tick x=28 <29 -> x=722, pipe1_y=105+LFSR; score +1 at 292 cross.
//  5 Bird y=100, pipe1_y=240, pipe1_x=340 (overlap) -> top-pipe hit, DEAD; next 5 ticks nothing moves.
//  6 iRST pulse mid-PLAY on a tick cycle -> all outputs equal reset values the same cycle; flap restarts.

Source files
------------

// File: rtl/flappy_game_engine.sv
// Per-frame game-state engine: bird physics, two scrolling pipe pairs, collision and scoring.
// Stage 1 updates state on the frame tick; stage 2 checks collisions on the following clock.
module flappy_game_engine #(
    parameter int DATA_W      = 11,
    parameter int SCREEN_H    = 480,
    parameter int BIRD_X      = 320,
    parameter int BIRD_W      = 45,
    parameter int BIRD_H      = 35,
    parameter int PIPE_W      = 54,
    parameter int GAP         = 150,
    parameter int GRAVITY     = 1,
    parameter int FLAP_VEL    = 9,
    parameter int MAX_FALL    = 10,
    parameter int SCROLL      = 2,
    parameter int BIRD_Y0     = 200,
    parameter int PIPE1_X0    = 640,
    parameter int SPACING     = 347,
    parameter int PIPE_Y0     = 240,
    parameter int PIPE_Y_BASE = 105,
    parameter logic [7:0] LFSR_SEED = 8'hB5
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFRAME_TICK,
    input  logic        iFLAP,
    output logic [31:0] bird_y_long,
    output logic [31:0] pipe1_x_long,
    output logic [31:0] pipe1_y_long,
    output logic [31:0] pipe2_x_long,
    output logic [31:0] pipe2_y_long,
    output logic        gameover_flag,
    output logic [15:0] oSCORE,
    output logic [1:0]  oSTATE
);

    localparam int HALF_W   = PIPE_W / 2;
    localparam int HALF_GAP = GAP / 2;
    localparam int WRAP     = 2 * SPACING;

    localparam logic [DATA_W-1:0] BIRD_Y0_L  = DATA_W'(BIRD_Y0);
    localparam logic [DATA_W-1:0] PIPE1_X0_L = DATA_W'(PIPE1_X0);
    localparam logic [DATA_W-1:0] PIPE2_X0_L = DATA_W'(PIPE1_X0 + SPACING);
    localparam logic [DATA_W-1:0] PIPE_Y0_L  = DATA_W'(PIPE_Y0);
    localparam logic [DATA_W-1:0] Y_BASE_L   = DATA_W'(PIPE_Y_BASE);
    localparam logic [DATA_W-1:0] SCROLL_L   = DATA_W'(SCROLL);
    localparam logic [DATA_W-1:0] WRAP_L     = DATA_W'(WRAP);
    localparam logic [DATA_W-1:0] X_WRAP_L   = DATA_W'(HALF_W + SCROLL);
    localparam logic [DATA_W-1:0] X_CROSS_L  = DATA_W'(BIRD_X - HALF_W);
    localparam logic [DATA_W-1:0] GROUND_L   = DATA_W'(SCREEN_H - BIRD_H);
    localparam logic signed [7:0] VEL_FLAP   = 8'(-FLAP_VEL);

    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DEAD = 2'b10} state_t;

    state_t                   state;
    logic                     flap_prev, flap_latch, vld_p1, gameover;
    logic [7:0]               lfsr;
    logic [DATA_W-1:0]        bird_y;
    logic signed [7:0]        vel;
    logic [DATA_W-1:0]        pipe_x [2];
    logic [DATA_W-1:0]        pipe_y [2];
    logic [15:0]              score;

    logic                     flap_edge, crash_p1;
    logic signed [7:0]        vel_p0;
    logic [DATA_W-1:0]        y_p0;
    logic [DATA_W-1:0]        pipe_x_p0 [2];
    logic                     wrap_p0 [2];
    logic [15:0]              score_p0;
    logic [1:0]               cross_cnt;
    logic [7:0]               lfsr_p0;

    function automatic logic signed [7:0] next_vel(input logic signed [7:0] v);
        logic signed [8:0] s;
        s = 9'(v) + 9'(GRAVITY);
        if (s > 9'(MAX_FALL)) return 8'(MAX_FALL);
        return s[7:0];
    endfunction

    function automatic logic [DATA_W-1:0] clamp_y(input logic [DATA_W-1:0] y,
                                                  input logic signed [7:0] v);
        logic signed [DATA_W+1:0] s;
        s = $signed({2'b00, y}) + (DATA_W+2)'(v);
        if (s[DATA_W+1]) return '0;
        return s[DATA_W-1:0];
    endfunction

    function automatic logic [15:0] sat_score(input logic [15:0] sc, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, sc} + 17'(inc);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Overlap and gap tests rearranged so no term can go below zero.
    function automatic logic pipe_hit(input logic [DATA_W-1:0] y, px, py);
        logic overlap;
        overlap = (px < DATA_W'(BIRD_X + BIRD_W + HALF_W)) && (px > X_CROSS_L);
        return overlap && ((y + DATA_W'(HALF_GAP) < py) || (y > py + DATA_W'(HALF_GAP - BIRD_H)));
    endfunction

    // Stage 1: next-frame values, committed on the tick edge
    always_comb begin
        logic [DATA_W-1:0] x_dec;
        flap_edge = iFLAP & ~flap_prev;
        lfsr_p0   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        vel_p0    = (flap_latch | flap_edge) ? VEL_FLAP : next_vel(vel);
        y_p0      = clamp_y(bird_y, vel_p0);
        cross_cnt = 2'd0;
        for (int i = 0; i < 2; i++) begin
            x_dec        = pipe_x[i] - SCROLL_L;
            wrap_p0[i]   = x_dec < X_WRAP_L;
            pipe_x_p0[i] = wrap_p0[i] ? x_dec + WRAP_L : x_dec;
            if (pipe_x[i] >= X_CROSS_L && x_dec < X_CROSS_L)
                cross_cnt = cross_cnt + 2'd1;
        end
        score_p0 = sat_score(score, cross_cnt);
        // Stage 2: collision on the registered stage-1 results
        crash_p1 = vld_p1 && ((bird_y >= GROUND_L) ||
                              pipe_hit(bird_y, pipe_x[0], pipe_y[0]) ||
                              pipe_hit(bird_y, pipe_x[1], pipe_y[1]));
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state      <= IDLE;
            flap_prev  <= 1'b0;
            flap_latch <= 1'b0;
            vld_p1     <= 1'b0;
            gameover   <= 1'b0;
            lfsr       <= LFSR_SEED;
            bird_y     <= BIRD_Y0_L;
            vel        <= '0;
            pipe_x[0]  <= PIPE1_X0_L;
            pipe_x[1]  <= PIPE2_X0_L;
            pipe_y[0]  <= PIPE_Y0_L;
            pipe_y[1]  <= PIPE_Y0_L;
            score      <= '0;
        end else begin
            flap_prev <= iFLAP;
            vld_p1    <= 1'b0;
            if (iFRAME_TICK)
                lfsr <= lfsr_p0;
            case (state)
                IDLE: begin
                    if (flap_edge) begin
                        state      <= PLAY;
                        flap_latch <= 1'b1;
                        score      <= '0;
                    end
                end
                PLAY: begin
                    if (iFRAME_TICK) begin
                        vel        <= vel_p0;
                        bird_y     <= y_p0;
                        score      <= score_p0;
                        flap_latch <= 1'b0;
                        vld_p1     <= 1'b1;
                        for (int i = 0; i < 2; i++) begin
                            pipe_x[i] <= pipe_x_p0[i];
                            if (wrap_p0[i])
                                pipe_y[i] <= Y_BASE_L + DATA_W'(lfsr);
                        end
                    end else if (flap_edge) begin
                        flap_latch <= 1'b1;
                    end
                    if (crash_p1) begin
                        state    <= DEAD;
                        gameover <= 1'b1;
                    end
                end
                DEAD: begin
                    // Restart returns everything but the score to power-up values
                    if (flap_edge) begin
                        state      <= IDLE;
                        gameover   <= 1'b0;
                        flap_latch <= 1'b0;
                        lfsr       <= LFSR_SEED;
                        bird_y     <= BIRD_Y0_L;
                        vel        <= '0;
                        pipe_x[0]  <= PIPE1_X0_L;
                        pipe_x[1]  <= PIPE2_X0_L;
                        pipe_y[0]  <= PIPE_Y0_L;
                        pipe_y[1]  <= PIPE_Y0_L;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bird_y_long   = 32'(bird_y);
    assign pipe1_x_long  = 32'(pipe_x[0]);
    assign pipe1_y_long  = 32'(pipe_y[0]);
    assign pipe2_x_long  = 32'(pipe_x[1]);
    assign pipe2_y_long  = 32'(pipe_y[1]);
    assign gameover_flag = gameover;
    assign oSCORE        = score;
    assign oSTATE        = state;

endmodule

// File: tb/tb_flappy_game_engine.sv
// Bench for flappy_game_engine: directed scenarios plus an autopilot-driven random run,
// all compared against a frame-level game model.
module tb_flappy_game_engine;

    logic        iCLK = 1'b0;
    logic        iRST, iFRAME_TICK, iFLAP;
    logic [31:0] bird_y_long, pipe1_x_long, pipe1_y_long, pipe2_x_long, pipe2_y_long;
    logic        gameover_flag;
    logic [15:0] oSCORE;
    logic [1:0]  oSTATE;
    logic [178:0] obs;

    int checks = 0;
    int passes = 0;

    flappy_game_engine dut (
        .iCLK(iCLK), .iRST(iRST), .iFRAME_TICK(iFRAME_TICK), .iFLAP(iFLAP),
        .bird_y_long(bird_y_long), .pipe1_x_long(pipe1_x_long), .pipe1_y_long(pipe1_y_long),
        .pipe2_x_long(pipe2_x_long), .pipe2_y_long(pipe2_y_long),
        .gameover_flag(gameover_flag), .oSCORE(oSCORE), .oSTATE(oSTATE)
    );

    always #5 iCLK = ~iCLK;

    assign obs = {bird_y_long, pipe1_x_long, pipe1_y_long, pipe2_x_long, pipe2_y_long,
                  gameover_flag, oSCORE, oSTATE};

    // Game model: state 0 idle, 1 playing, 2 dead
    int         m_state, m_y, m_vel, m_score;
    int         m_px [2];
    int         m_py [2];
    bit         m_latch, m_over, m_wrap1;
    logic [7:0] m_lfsr;

    function automatic logic [178:0] exp_vec();
        return {32'(m_y), 32'(m_px[0]), 32'(m_py[0]), 32'(m_px[1]), 32'(m_py[1]),
                m_over, 16'(m_score), 2'(m_state)};
    endfunction

    task automatic model_reinit();
        m_state = 0; m_y = 200; m_vel = 0; m_latch = 0; m_over = 0;
        m_px[0] = 640; m_px[1] = 987; m_py[0] = 240; m_py[1] = 240;
        m_lfsr = 8'hB5;
    endtask

    task automatic model_reset();
        model_reinit();
        m_score = 0;
    endtask

    task automatic model_press();
        case (m_state)
            0: begin m_state = 1; m_latch = 1; m_score = 0; end
            1: m_latch = 1;
            default: model_reinit();
        endcase
    endtask

    task automatic model_tick();
        int nx;
        bit dead;
        if (m_state == 1) begin
            if (m_latch) m_vel = -9;
            else m_vel = (m_vel + 1 > 10) ? 10 : m_vel + 1;
            m_latch = 0;
            m_y = m_y + m_vel;
            if (m_y < 0) m_y = 0;
            for (int i = 0; i < 2; i++) begin
                nx = m_px[i] - 2;
                if (m_px[i] >= 293 && nx < 293 && m_score < 65535) m_score++;
                if (nx < 29) begin
                    nx = nx + 694;
                    m_py[i] = 105 + int'(m_lfsr);
                    if (i == 0) m_wrap1 = 1;
                end
                m_px[i] = nx;
            end
            dead = (m_y + 35 >= 480);
            for (int i = 0; i < 2; i++)
                if ((320 + 45 > m_px[i] - 27) && (320 < m_px[i] + 27) &&
                    (m_y < m_py[i] - 75 || m_y + 35 > m_py[i] + 75))
                    dead = 1;
            if (dead) begin m_state = 2; m_over = 1; end
        end
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    task automatic do_reset();
        iRST = 1'b1; iFLAP = 1'b0; iFRAME_TICK = 1'b0;
        model_reset();
        repeat (2) @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);
    endtask

    task automatic press_flap();
        @(negedge iCLK); iFLAP = 1'b1;
        @(negedge iCLK); iFLAP = 1'b0;
        model_press();
    endtask

    task automatic pulse_tick();
        @(negedge iCLK); iFRAME_TICK = 1'b1;
        @(negedge iCLK); iFRAME_TICK = 1'b0;
        model_tick();
    endtask

    task automatic drive_frame(input bit press);
        if (press) press_flap();
        pulse_tick();
        @(negedge iCLK);
    endtask

    task automatic test_reset();
        iRST = 1'b1; iFLAP = 1'b0; iFRAME_TICK = 1'b0;
        model_reset();
        repeat (2) @(negedge iCLK);
        checks++;
        if (obs !== exp_vec()) $display("FAIL reset_held: got %h want %h", obs, exp_vec());
        else passes++;
        iRST = 1'b0;
        @(negedge iCLK);
        checks++;
        if (obs !== exp_vec()) $display("FAIL reset_released: got %h want %h", obs, exp_vec());
        else passes++;
    endtask

    task automatic test_idle_hold();
        do_reset();
        for (int f = 0; f < 10; f++) begin
            drive_frame(1'b0);
            checks++;
            if (obs !== exp_vec() || bird_y_long !== 32'd200 || pipe1_x_long !== 32'd640 ||
                gameover_flag !== 1'b0 || oSTATE !== 2'b00)
                $display("FAIL idle_hold frame %0d: got %h want %h", f, obs, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_flap_ascent();
        int want_y [3] = '{191, 183, 176};
        int want_x [3] = '{638, 636, 634};
        do_reset();
        for (int f = 0; f < 3; f++) begin
            drive_frame(f == 0);
            checks++;
            if (obs !== exp_vec() || bird_y_long !== 32'(want_y[f]) ||
                pipe1_x_long !== 32'(want_x[f]) || oSTATE !== 2'b01)
                $display("FAIL flap_ascent frame %0d: got y=%0d x=%0d st=%0d want y=%0d x=%0d st=1",
                         f, bird_y_long, pipe1_x_long, oSTATE, want_y[f], want_x[f]);
            else passes++;
        end
    endtask

    task automatic test_ground_death();
        int prev_y;
        bit died;
        logic [178:0] snap;
        do_reset();
        press_flap();
        died = 0;
        prev_y = m_y;
        for (int f = 0; f < 80 && !died; f++) begin
            prev_y = m_y;
            pulse_tick();
            checks++;
            if (gameover_flag !== 1'b0 || bird_y_long !== 32'(m_y))
                $display("FAIL ground_stage1 frame %0d: got go=%b y=%0d want go=0 y=%0d",
                         f, gameover_flag, bird_y_long, m_y);
            else passes++;
            @(negedge iCLK);
            checks++;
            if (obs !== exp_vec()) $display("FAIL ground_frame %0d: got %h want %h", f, obs, exp_vec());
            else passes++;
            died = (m_state == 2);
        end
        checks++;
        if (oSTATE !== 2'b10 || gameover_flag !== 1'b1)
            $display("FAIL ground_dead: got st=%0d go=%b want st=2 go=1", oSTATE, gameover_flag);
        else passes++;
        checks++;
        if (bird_y_long + 32'd35 < 32'd480 || bird_y_long - 32'(prev_y) !== 32'd10)
            $display("FAIL ground_fall: got y=%0d prev=%0d want y+35>=480 step=10", bird_y_long, prev_y);
        else passes++;
        snap = exp_vec();
        for (int f = 0; f < 5; f++) begin
            drive_frame(1'b0);
            checks++;
            if (obs !== snap) $display("FAIL dead_frozen frame %0d: got %h want %h", f, obs, snap);
            else passes++;
        end
    endtask

    task automatic test_restart();
        press_flap();
        checks++;
        if (obs !== exp_vec() || gameover_flag !== 1'b0 || oSTATE !== 2'b00)
            $display("FAIL restart_idle: got %h want %h", obs, exp_vec());
        else passes++;
        drive_frame(1'b1);
        checks++;
        if (obs !== exp_vec() || bird_y_long !== 32'd191 || oSCORE !== 16'd0 || oSTATE !== 2'b01)
            $display("FAIL restart_play: got %h want %h", obs, exp_vec());
        else passes++;
    endtask

    task automatic test_autoplay(input int frames);
        int  near;
        bit  press;
        int  best_score;
        best_score = 0;
        do_reset();
        for (int f = 0; f < frames; f++) begin
            press = 0;
            m_wrap1 = 0;
            if (m_state != 1) begin
                press = ($urandom_range(0, 3) == 0);
            end else begin
                near = (m_px[0] + 27 >= 310 && (m_px[0] < m_px[1] || m_px[1] + 27 < 310)) ? 0 : 1;
                press = (m_y + 17 > m_py[near] + 10) && (m_vel >= 0);
                if ($urandom_range(0, 15) == 0) press = !press;
            end
            drive_frame(press);
            repeat ($urandom_range(0, 2)) @(negedge iCLK);
            checks++;
            if (obs !== exp_vec()) $display("FAIL autoplay frame %0d: got %h want %h", f, obs, exp_vec());
            else passes++;
            if (m_wrap1) begin
                checks++;
                if (pipe1_x_long !== 32'd722 || pipe1_y_long < 32'd105 || pipe1_y_long > 32'd360)
                    $display("FAIL pipe_wrap frame %0d: got x=%0d y=%0d want x=722 y in 105..360",
                             f, pipe1_x_long, pipe1_y_long);
                else passes++;
            end
            if (m_score > best_score) best_score = m_score;
        end
        $display("autoplay best score %0d", best_score);
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        drive_frame(1'b1);
        drive_frame(1'b0);
        @(negedge iCLK);
        iFRAME_TICK = 1'b1;
        iRST = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs !== exp_vec()) $display("FAIL reset_async: got %h want %h", obs, exp_vec());
        else passes++;
        @(posedge iCLK);
        #1;
        checks++;
        if (obs !== exp_vec()) $display("FAIL reset_no_update: got %h want %h", obs, exp_vec());
        else passes++;
        @(negedge iCLK);
        iRST = 1'b0;
        iFRAME_TICK = 1'b0;
        drive_frame(1'b1);
        checks++;
        if (obs !== exp_vec() || bird_y_long !== 32'd191 || oSTATE !== 2'b01)
            $display("FAIL reset_replay: got %h want %h", obs, exp_vec());
        else passes++;
    endtask

    initial begin
        iRST = 1'b1; iFLAP = 1'b0; iFRAME_TICK = 1'b0;
        test_reset();
        test_idle_hold();
        test_flap_ascent();
        test_ground_death();
        test_restart();
        test_autoplay(900);
        test_reset_mid_play();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
